// File: rtl/view_select_mux_if.sv
// Pixel and control bundle for view_select_mux: master is the stream/config source, slave is the mux.
interface view_select_mux_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 12
);
    logic [3:0]               mode_req;
    logic [3:0]               bg_sel;
    logic [CNT_W-1:0]         win_x0;
    logic [CNT_W-1:0]         win_x1;
    logic [CNT_W-1:0]         win_y0;
    logic [CNT_W-1:0]         win_y1;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_sof;
    logic                     out_eol;
    logic [3:0]               cur_mode;
    logic                     mode_pending;

    modport master (
        output mode_req, bg_sel, win_x0, win_x1, win_y0, win_y1, in_data, in_valid,
        input  out_data, out_valid, out_sof, out_eol, cur_mode, mode_pending
    );

    modport slave (
        input  mode_req, bg_sel, win_x0, win_x1, win_y0, win_y1, in_data, in_valid,
        output out_data, out_valid, out_sof, out_eol, cur_mode, mode_pending
    );
endinterface

// File: rtl/view_select_mux.sv
// Registered foreground/background video selector; mode and window change only on frame boundaries.
// Optional window outline overlay is enabled by defining VIEW_MUX_BORDER_EN.
module view_select_mux #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16,
    parameter int H_ACT  = 800,
    parameter int V_ACT  = 600,
    parameter int CNT_W  = 12,
    parameter int REF_CH = 0
`ifdef VIEW_MUX_BORDER_EN
    ,
    parameter logic [DATA_W-1:0] BORDER_COLOR = DATA_W'(16'hF800)
`endif
) (
    input logic              clk,
    input logic              rst,
    view_select_mux_if.slave bus
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [4:0]       NUM_CH_W = 5'(NUM_CH);

    logic [CNT_W-1:0]  cnt_x_r;
    logic [CNT_W-1:0]  cnt_y_r;
    logic [CNT_W-1:0]  win_x0_r;
    logic [CNT_W-1:0]  win_x1_r;
    logic [CNT_W-1:0]  win_y0_r;
    logic [CNT_W-1:0]  win_y1_r;
    logic [3:0]        cur_mode_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              out_sof_r;
    logic              out_eol_r;

    logic              ref_vld_s;
    logic              sof_s;
    logic              eol_s;
    logic              mode_ok_s;
    logic              inwin_s;
    logic              sel_vld_s;
    logic [3:0]        fg_mode_s;
    logic [3:0]        bg_s;
    logic [3:0]        sel_s;
    logic [CNT_W-1:0]  wx0_s;
    logic [CNT_W-1:0]  wx1_s;
    logic [CNT_W-1:0]  wy0_s;
    logic [CNT_W-1:0]  wy1_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [DATA_W-1:0] pix_s;

    // Raster decode; the boundary pixel already sees the freshly requested mode and window
    always_comb begin
        ref_vld_s = bus.in_valid[REF_CH];
        sof_s     = ref_vld_s && (cnt_x_r == CNT_ZERO) && (cnt_y_r == CNT_ZERO);
        eol_s     = ref_vld_s && (cnt_x_r == H_LAST);
        mode_ok_s = ({1'b0, bus.mode_req} < NUM_CH_W);
        if (sof_s) begin
            if (mode_ok_s) begin
                fg_mode_s = bus.mode_req;
            end else begin
                fg_mode_s = cur_mode_r;
            end
            wx0_s = bus.win_x0;
            wx1_s = bus.win_x1;
            wy0_s = bus.win_y0;
            wy1_s = bus.win_y1;
        end else begin
            fg_mode_s = cur_mode_r;
            wx0_s     = win_x0_r;
            wx1_s     = win_x1_r;
            wy0_s     = win_y0_r;
            wy1_s     = win_y1_r;
        end
        if ({1'b0, bus.bg_sel} < NUM_CH_W) begin
            bg_s = bus.bg_sel;
        end else begin
            bg_s = 4'd0;
        end
        // An inverted bound pair can never satisfy both compares, so the window is empty
        inwin_s = (cnt_x_r >= wx0_s) && (cnt_x_r <= wx1_s) &&
                  (cnt_y_r >= wy0_s) && (cnt_y_r <= wy1_s);
        if (inwin_s) begin
            sel_s = fg_mode_s;
        end else begin
            sel_s = bg_s;
        end
    end

    // AND-OR channel mux; sel_s is always below NUM_CH
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        sel_vld_s  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_data_s = sel_data_s | ({DATA_W{sel_s == 4'(k)}} & bus.in_data[k*DATA_W +: DATA_W]);
            sel_vld_s  = sel_vld_s | ((sel_s == 4'(k)) & bus.in_valid[k]);
        end
    end

    // Window perimeter overlay
    always_comb begin
`ifdef VIEW_MUX_BORDER_EN
        if (inwin_s && ((cnt_x_r == wx0_s) || (cnt_x_r == wx1_s) ||
                        (cnt_y_r == wy0_s) || (cnt_y_r == wy1_s))) begin
            pix_s = BORDER_COLOR;
        end else begin
            pix_s = sel_data_s;
        end
`else
        pix_s = sel_data_s;
`endif
    end

    // Raster counters, frame-latched mode/window and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_x_r     <= CNT_ZERO;
            cnt_y_r     <= CNT_ZERO;
            cur_mode_r  <= 4'd0;
            win_x0_r    <= CNT_ZERO;
            win_x1_r    <= H_LAST;
            win_y0_r    <= CNT_ZERO;
            win_y1_r    <= V_LAST;
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eol_r   <= 1'b0;
        end else begin
            if (ref_vld_s) begin
                if (eol_s) begin
                    cnt_x_r <= CNT_ZERO;
                    if (cnt_y_r == V_LAST) begin
                        cnt_y_r <= CNT_ZERO;
                    end else begin
                        cnt_y_r <= cnt_y_r + CNT_ONE;
                    end
                end else begin
                    cnt_x_r <= cnt_x_r + CNT_ONE;
                end
            end
            if (sof_s) begin
                cur_mode_r <= fg_mode_s;
                win_x0_r   <= wx0_s;
                win_x1_r   <= wx1_s;
                win_y0_r   <= wy0_s;
                win_y1_r   <= wy1_s;
            end
            if (sel_vld_s) begin
                out_data_r <= pix_s;
            end
            out_valid_r <= sel_vld_s;
            out_sof_r   <= sof_s;
            out_eol_r   <= eol_s;
        end
    end

    assign bus.out_data     = out_data_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_sof      = out_sof_r;
    assign bus.out_eol      = out_eol_r;
    assign bus.cur_mode     = cur_mode_r;
    assign bus.mode_pending = (bus.mode_req != cur_mode_r);
endmodule

// File: tb/tb_view_select_mux.sv
// Scoreboard bench for view_select_mux on a reduced 64x48 raster; border checks follow VIEW_MUX_BORDER_EN.
module tb_view_select_mux;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 16;
    localparam int H      = 64;
    localparam int V      = 48;
    localparam int CNT_W  = 12;
`ifdef VIEW_MUX_BORDER_EN
    localparam logic [15:0] EDGE_PIX = 16'hF800;
`else
    localparam logic [15:0] EDGE_PIX = 16'h3000;
`endif

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic        sof;
        logic        eol;
        logic        ref_v;
        logic [3:0]  mode;
        int          x;
        int          y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    view_select_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    view_select_mux #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .H_ACT(H), .V_ACT(V), .CNT_W(CNT_W), .REF_CH(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        sb[$];
    exp_t        last_e;
    int          n_total = 0;
    int          n_bad   = 0;
    int          m_x = 0, m_y = 0, m_mode = 0;
    int          m_wx0 = 0, m_wx1 = H - 1, m_wy0 = 0, m_wy1 = V - 1;
    logic [15:0] m_data = 16'h0000;
    logic        rand_data = 1'b0;
    logic        rand_vld  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic set_win(input int x0, input int x1, input int y0, input int y1);
        bus.win_x0 = 12'(x0);
        bus.win_x1 = 12'(x1);
        bus.win_y0 = 12'(y0);
        bus.win_y1 = 12'(y1);
    endtask

    task automatic drive(input logic gap);
        for (int k = 0; k < NUM_CH; k++) begin
            bus.in_data[k*DATA_W +: DATA_W] = rand_data ? 16'($urandom) : 16'(32'h1000 * k);
            if (gap)
                bus.in_valid[k] = 1'b0;
            else if (rand_vld && k != 0)
                bus.in_valid[k] = ($urandom_range(0, 3) != 0);
            else
                bus.in_valid[k] = 1'b1;
        end
    endtask

    // One pixel clock: predict the registered output, push it, then compare after the edge.
    task automatic cycle();
        exp_t              e;
        exp_t              got;
        logic [NUM_CH-1:0] v;
        int                bg, sel;
        logic              inw, rv;
        #1;
        check_val("mode_pending", bus.mode_pending, bus.mode_req != 4'(m_mode));
        e = '{default: 0};
        if (rst) begin
            m_x = 0; m_y = 0; m_mode = 0; m_data = 16'h0000;
            m_wx0 = 0; m_wx1 = H - 1; m_wy0 = 0; m_wy1 = V - 1;
        end else begin
            v = bus.in_valid;
            rv = v[0];
            e.ref_v = rv; e.x = m_x; e.y = m_y;
            e.sof = rv && m_x == 0 && m_y == 0;
            if (e.sof) begin
                if (int'(bus.mode_req) < NUM_CH) m_mode = int'(bus.mode_req);
                m_wx0 = int'(bus.win_x0); m_wx1 = int'(bus.win_x1);
                m_wy0 = int'(bus.win_y0); m_wy1 = int'(bus.win_y1);
            end
            bg  = (int'(bus.bg_sel) < NUM_CH) ? int'(bus.bg_sel) : 0;
            inw = (m_x >= m_wx0) && (m_x <= m_wx1) && (m_y >= m_wy0) && (m_y <= m_wy1);
            sel = inw ? m_mode : bg;
            e.valid = v[sel];
            if (e.valid) begin
                m_data = bus.in_data[sel*DATA_W +: DATA_W];
`ifdef VIEW_MUX_BORDER_EN
                if (inw && (m_x == m_wx0 || m_x == m_wx1 || m_y == m_wy0 || m_y == m_wy1))
                    m_data = 16'hF800;
`endif
            end
            e.data = m_data;
            e.eol  = rv && (m_x == H - 1);
            e.mode = 4'(m_mode);
            if (rv) begin
                if (m_x == H - 1) begin
                    m_x = 0;
                    m_y = (m_y == V - 1) ? 0 : m_y + 1;
                end else begin
                    m_x = m_x + 1;
                end
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        last_e = got;
        check_val("out_data", bus.out_data, got.data);
        check_val("out_valid", bus.out_valid, got.valid);
        check_val("out_sof", bus.out_sof, got.sof);
        check_val("out_eol", bus.out_eol, got.eol);
        check_val("cur_mode", bus.cur_mode, got.mode);
    endtask

    // Directed spot checks at known raster positions (ph 40 = frame restarted after reset)
    task automatic pos_checks(input int ph, input int x, input int y);
        if (ph == 0) begin
            if (x == 15 && y == 5) check_val("roi_first_pixel", bus.out_data, EDGE_PIX);
            if (x == 14 && y == 5) check_val("left_of_roi", bus.out_data, 16'h0000);
            if (x == 0 && y == 0) begin
                check_val("sof_origin", bus.out_sof, 1'b1);
                check_val("mode3_applied", bus.cur_mode, 4'd3);
            end
            if (x == 1 && y == 0) check_val("sof_only_origin", bus.out_sof, 1'b0);
        end else if (ph == 1) begin
            if (x == 20 && y == 20) begin
                check_val("old_mode_kept", bus.out_data, 16'h3000);
                check_val("pending_set", bus.mode_pending, 1'b1);
                check_val("cur_mode_old", bus.cur_mode, 4'd3);
            end
        end else if (ph == 2) begin
            if (x == 0 && y == 0) begin
                check_val("mode5_applied", bus.cur_mode, 4'd5);
                check_val("pending_clear", bus.mode_pending, 1'b0);
            end
            if (x == 20 && y == 20) check_val("mode5_pixel", bus.out_data, 16'h5000);
        end else if (ph == 3) begin
            if (x == 0 && y == 0) begin
                check_val("bad_mode_hold", bus.cur_mode, 4'd5);
                check_val("bad_mode_pending", bus.mode_pending, 1'b1);
            end
            if (x == 20 && y == 20) check_val("empty_win_bg2", bus.out_data, 16'h2000);
            if (x == 20 && y == 35) check_val("bg_oob_ch0", bus.out_data, 16'h0000);
        end else if (ph == 4) begin
            if (x == 0 && y == 0) check_val("bad_mode_hold2", bus.cur_mode, 4'd5);
            if (x == 20 && y == 20) check_val("win_restored", bus.out_data, 16'h5000);
        end else if (ph == 40) begin
            if (x == 0 && y == 0) check_val("mode_after_rst", bus.cur_mode, 4'd0);
            if (x == 20 && y == 20) check_val("ch0_after_rst", bus.out_data, 16'h0000);
        end else if (ph == 6) begin
            if (x == 10 && y == 15) check_val("border_left", bus.out_data, EDGE_PIX);
            if (x == 20 && y == 10) check_val("border_corner", bus.out_data, EDGE_PIX);
            if (x == 15 && y == 15) check_val("border_inside", bus.out_data, 16'h3000);
            if (x == 9 && y == 10) check_val("border_outside", bus.out_data, 16'h0000);
        end
    endtask

    task automatic run_frame(input int ph);
        int   n = 0;
        logic gap, rst_now;
        logic did_rst   = 1'b0;
        logic after_rst = 1'b0;
        rand_data = (ph == 5);
        rand_vld  = (ph == 5);
        while (n < H * V) begin
            rst_now = 1'b0;
            if (ph == 1 && m_x == 40 && m_y == 10) bus.mode_req = 4'd5;
            if (ph == 2 && m_x == 0 && m_y == 40) begin
                bus.mode_req = 4'd12;
                set_win(50, 10, 5, 35);
            end
            if (ph == 3 && m_x == 0 && m_y == 30) bus.bg_sel = 4'd9;
            if (ph == 3 && m_x == 0 && m_y == 40) begin
                set_win(15, 45, 5, 35);
                bus.bg_sel = 4'd1;
            end
            if (ph == 4 && m_x == 30 && m_y == 20 && !did_rst) rst_now = 1'b1;
            if (ph == 5 && m_x == 0) begin
                bus.mode_req = 4'($urandom_range(0, 15));
                bus.bg_sel   = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0)
                    set_win($urandom_range(0, 63), $urandom_range(0, 63),
                            $urandom_range(0, 47), $urandom_range(0, 47));
            end
            gap = (ph >= 3 && ph <= 5 && !rst_now) ? ($urandom_range(0, 7) == 0) : 1'b0;
            rst = rst_now;
            drive(gap);
            cycle();
            rst = 1'b0;
            if (rst_now) begin
                check_val("rst_out_data", bus.out_data, 16'h0000);
                check_val("rst_out_valid", bus.out_valid, 1'b0);
                check_val("rst_cur_mode", bus.cur_mode, 4'd0);
                did_rst = 1'b1;
                after_rst = 1'b1;
                n = 0;
            end else if (!gap) begin
                n++;
                if (after_rst) begin
                    check_val("sof_after_rst", bus.out_sof, 1'b1);
                    after_rst = 1'b0;
                end
                pos_checks(did_rst ? 40 : ph, last_e.x, last_e.y);
            end
        end
    endtask

    initial begin
        bus.mode_req = 4'd0;
        bus.bg_sel   = 4'd0;
        set_win(0, 0, 0, 0);
        bus.in_data  = '0;
        bus.in_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_out_data", bus.out_data, 16'h0000);
        check_val("reset_out_valid", bus.out_valid, 1'b0);
        check_val("reset_out_sof", bus.out_sof, 1'b0);
        check_val("reset_out_eol", bus.out_eol, 1'b0);
        check_val("reset_cur_mode", bus.cur_mode, 4'd0);
        check_val("reset_pending", bus.mode_pending, 1'b0);
        rst = 1'b0;

        bus.mode_req = 4'd3;
        set_win(15, 45, 5, 35);
        run_frame(0);
        run_frame(1);
        run_frame(2);
        bus.bg_sel = 4'd2;
        run_frame(3);
        run_frame(4);
        run_frame(5);
        bus.mode_req = 4'd3;
        bus.bg_sel   = 4'd0;
        set_win(10, 20, 10, 20);
        run_frame(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/view_select_mux.md
# view_select_mux

Parametrised, registered video-path selector for the gesture-recognition pipeline. It sits between the parallel processing stages (original, gray, median, Sobel, erosion, dilation and later stages) and the display/SDRAM writer. It picks one of `NUM_CH` pixel streams for a rectangular region of interest and a background stream outside it. Mode changes take effect only on frame boundaries, so no frame is ever torn.

## Interface
Parameters:
- `NUM_CH`, 8, number of input streams (2..16)
- `DATA_W`, 16, pixel width (RGB565)
- `H_ACT`, 800, active pixels per line
- `V_ACT`, 600, active lines per frame
- `CNT_W`, 12, raster counter width
- `REF_CH`, 0, channel whose valid drives the raster counters
- `BORDER_COLOR`, 16'hF800, window outline colour (only with `VIEW_MUX_BORDER_EN`)

Ports:
- `clk`  in  1  pixel clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset
- `mode_req`  in  4  requested foreground channel index
- `bg_sel`  in  4  background channel index, used outside the window
- `win_x0`, `win_x1`  in  CNT_W  window column bounds, inclusive
- `win_y0`, `win_y1`  in  CNT_W  window row bounds, inclusive
- `in_data`  in  NUM_CH*DATA_W  packed pixels; channel k is at bits [k*DATA_W +: DATA_W]
- `in_valid`  in  NUM_CH  per-channel pixel valid; all channels are pipeline-aligned
- `out_data`  out  DATA_W  selected pixel, registered
- `out_valid`  out  1  output pixel valid
- `out_sof`  out  1  high with the pixel at (0,0)
- `out_eol`  out  1  high with the pixel at column H_ACT-1
- `cur_mode`  out  4  foreground index currently applied
- `mode_pending`  out  1  `mode_req` differs from `cur_mode` and has not been applied yet

## Operation
- Raster counters:
  - `cnt_x` increments on `in_valid[REF_CH]` and wraps from H_ACT-1 to 0.
  - On that wrap, `cnt_y` increments; it wraps from V_ACT-1 to 0.
  - Counters hold when `in_valid[REF_CH]` is low.
- Frame boundary: the cycle where `in_valid[REF_CH]`=1, `cnt_x`=0 and `cnt_y`=0.
- Mode latch:
  - At a frame boundary, `cur_mode` loads `mode_req`, but only if `mode_req` < NUM_CH; otherwise `cur_mode` holds.
  - The boundary pixel itself already uses the new mode.
  - `mode_pending` is combinational: `mode_req` != `cur_mode`.
- Window test: `inwin` = (`win_x0` ≤ `cnt_x` ≤ `win_x1`) and (`win_y0` ≤ `cnt_y` ≤ `win_y1`). If `win_x0` > `win_x1` or `win_y0` > `win_y1`, the window is empty and the whole frame shows background.
- Window bounds are sampled at the frame boundary into shadow registers. Mid-frame changes therefore apply from the next frame.
- Background select: `bg_sel` ≥ NUM_CH selects channel 0. `bg_sel` is sampled live, not shadowed.
- Output:
  - If `inwin`, `out_data` = `in_data[cur_mode]` and `out_valid` = `in_valid[cur_mode]`.
  - Otherwise, `out_data` = `in_data[bg]` and `out_valid` = `in_valid[bg]`.
  - When the selected valid is low, `out_data` holds its previous value.

## Timing
- All outputs are registered. Latency is 1 clk from input pixel to `out_data`/`out_valid`/`out_sof`/`out_eol`.
- `cur_mode` updates on the clk edge that ends the boundary cycle; the boundary pixel's output already reflects the new mode.
- Reset values:
  - `out_data`=0, `out_valid`=0, `out_sof`=0, `out_eol`=0
  - `cur_mode`=0, counters=0
  - shadow window = full frame (0..H_ACT-1, 0..V_ACT-1)
- Reset mid-frame: counters return to 0. The next `in_valid[REF_CH]` is treated as pixel (0,0) and is a frame boundary.
- Simultaneous `mode_req` change and boundary cycle: the value present in that cycle is applied.
- Counter width rule: CNT_W ≥ clog2(max(H_ACT, V_ACT)). Comparisons are unsigned.

## Configuration
- `VIEW_MUX_BORDER_EN`:
  - Defined: output pixels on the window perimeter are replaced by `BORDER_COLOR`. Perimeter means `inwin` and (`cnt_x`=`win_x0` or `win_x1` or `cnt_y`=`win_y0` or `win_y1`). `out_valid` is unchanged.
  - Undefined: no overlay, and the `BORDER_COLOR` logic is absent.

## Test plan
- Reset, then one frame with NUM_CH=8, ch k data = 16'h1000*k, `mode_req`=3, window 150..450 × 50..350, `bg_sel`=0 → 1-cycle latency, (150,50) outputs 16'h3000, (149,50) outputs 16'h0000, `out_sof` only at (0,0).
- `mode_req` 3→5 at pixel (400,100) → rest of frame still shows 16'h3000 inside the window, `mode_pending`=1; next frame's (0,0) applies mode 5 and `mode_pending` drops.
- `mode_req`=12 with NUM_CH=8 → `cur_mode` holds its previous value across frames; `mode_pending` stays 1.
- Empty window (`win_x0`=500, `win_x1`=100) → every pixel comes from the background channel.
- `rst` pulse at pixel (300,200) → outputs 0; next ref-valid pixel produces `out_sof`=1.
- With `VIEW_MUX_BORDER_EN`, window 10..20 × 10..20 → pixels (10,15) and (20,10) show 16'hF800, (15,15) shows foreground, (9,10) shows background.
